// File: rtl/codificador_sequencial.sv
// codificador_sequencial: sequential priority encoder.
// Captures a request vector and hands out the index of each set bit,
// one per valid/ready transfer, lowest-first or highest-first.
module codificador_sequencial #(
    parameter int LARGURA      = 8,
    parameter int SEL          = 3,
    parameter int MSB_PRIMEIRO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               load,
    input  logic [LARGURA-1:0] y,
    input  logic               ready,
    output logic [SEL-1:0]     a,
    output logic               valid,
    output logic               busy,
    output logic               vazio,
    output logic               done,
    output logic [SEL:0]       qtd
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } estado_t;

    estado_t            estado, prox_estado;
    logic [LARGURA-1:0] pend, pend_prox, pend_limpo;
    logic [SEL:0]       qtd_prox, contagem;
    logic               vazio_prox, done_prox;
    logic [SEL-1:0]     indice;
    logic               aceita, transfere;

    // Priority index of pending bits; the last match in scan order wins.
    always_comb begin
        int unsigned idx;
        logic [SEL-1:0] pos;
        indice = '0;
        for (int unsigned i = 0; i < LARGURA; i++) begin
            idx = (MSB_PRIMEIRO != 0) ? i : (LARGURA - 1 - i);
            pos = idx[SEL-1:0];
            if (pend[pos]) indice = pos;
        end
    end

    // Population count of the incoming request vector.
    always_comb begin
        contagem = '0;
        for (int unsigned i = 0; i < LARGURA; i++) begin
            contagem = contagem + {{SEL{1'b0}}, y[i]};
        end
    end

    // Pending vector with the currently offered bit removed.
    always_comb begin
        pend_limpo         = pend;
        pend_limpo[indice] = 1'b0;
    end

    assign aceita    = (estado == IDLE) && enable && load;
    assign transfere = (estado == EMIT) && enable && ready;

    // Next-state logic for the IDLE/EMIT controller.
    always_comb begin
        prox_estado = estado;
        pend_prox   = pend;
        qtd_prox    = qtd;
        vazio_prox  = 1'b0;
        done_prox   = 1'b0;
        case (estado)
            IDLE: begin
                if (aceita) begin
                    pend_prox = y;
                    qtd_prox  = contagem;
                    if (y != '0) prox_estado = EMIT;
                    else         vazio_prox  = 1'b1;
                end
            end
            EMIT: begin
                if (transfere) begin
                    pend_prox = pend_limpo;
                    if (pend_limpo == '0) begin
                        prox_estado = IDLE;
                        done_prox   = 1'b1;
                    end
                end
            end
            default: prox_estado = IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
            pend   <= '0;
            qtd    <= '0;
            vazio  <= 1'b0;
            done   <= 1'b0;
        end else begin
            estado <= prox_estado;
            pend   <= pend_prox;
            qtd    <= qtd_prox;
            vazio  <= vazio_prox;
            done   <= done_prox;
        end
    end

    // pend is all-zero outside EMIT, so the index reads 0 when idle.
    assign a     = indice;
    assign valid = (estado == EMIT) && enable;
    assign busy  = (estado == EMIT);

endmodule

// File: tb/tb_codificador_sequencial.sv
// Directed self-checking bench for codificador_sequencial.
// Two instances share stimulus: dut0 is LSB-first, dut1 is MSB-first.
// Observed vector layout: {a[2:0], valid, busy, done, vazio, qtd[3:0]}.
module tb_codificador_sequencial;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       load;
    logic [7:0] y;
    logic       ready;

    logic [2:0] a0, a1;
    logic       valid0, valid1, busy0, busy1, vazio0, vazio1, done0, done1;
    logic [3:0] qtd0, qtd1;
    logic [10:0] st0, st1;

    int checks = 0;
    int errors = 0;

    codificador_sequencial #(.LARGURA(8), .SEL(3), .MSB_PRIMEIRO(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .y(y), .ready(ready),
        .a(a0), .valid(valid0), .busy(busy0), .vazio(vazio0), .done(done0), .qtd(qtd0)
    );

    codificador_sequencial #(.LARGURA(8), .SEL(3), .MSB_PRIMEIRO(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .y(y), .ready(ready),
        .a(a1), .valid(valid1), .busy(busy1), .vazio(vazio1), .done(done1), .qtd(qtd1)
    );

    assign st0 = {a0, valid0, busy0, done0, vazio0, qtd0};
    assign st1 = {a1, valid1, busy1, done1, vazio1, qtd1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] exp;
        exp = '0;
        checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_initial: got %b expected %b", st0, exp); end
        rst = 1'b0;
        tick;
        checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_release: got %b expected %b", st0, exp); end
        ready = 1'b0; load = 1'b1; y = 8'hFF;
        tick;
        load = 1'b0; y = 8'h00;
        exp = {3'd0, 4'b1100, 4'd8};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_load_ff: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd7, 4'b1100, 4'd8};
        checks++; if (st1 !== exp) begin errors++; $display("FAIL reset_load_ff_msb: got %b expected %b", st1, exp); end
        #2 rst = 1'b1;
        #1;
        exp = '0;
        checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_async: got %b expected %b", st0, exp); end
        checks++; if (st1 !== exp) begin errors++; $display("FAIL reset_async_msb: got %b expected %b", st1, exp); end
        rst = 1'b0;
        tick;
        checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_after_release: got %b expected %b", st0, exp); end
    endtask

    task automatic test_lsb_stream;
        logic [10:0] exp;
        logic [2:0] e0 [4];
        logic [2:0] e1 [4];
        e0 = '{3'd1, 3'd2, 3'd5, 3'd7};
        e1 = '{3'd7, 3'd5, 3'd2, 3'd1};
        ready = 1'b1; load = 1'b1; y = 8'b1010_0110;
        tick;
        load = 1'b0; y = 8'h00;
        for (int k = 0; k < 4; k++) begin
            exp = {e0[k], 4'b1100, 4'd4};
            checks++; if (st0 !== exp) begin errors++; $display("FAIL lsb_stream step %0d: got %b expected %b", k, st0, exp); end
            exp = {e1[k], 4'b1100, 4'd4};
            checks++; if (st1 !== exp) begin errors++; $display("FAIL msb_stream step %0d: got %b expected %b", k, st1, exp); end
            tick;
        end
        exp = {3'd0, 4'b0010, 4'd4};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL lsb_stream_done: got %b expected %b", st0, exp); end
        checks++; if (st1 !== exp) begin errors++; $display("FAIL msb_stream_done: got %b expected %b", st1, exp); end
        tick;
        exp = {3'd0, 4'b0000, 4'd4};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL lsb_stream_after: got %b expected %b", st0, exp); end
    endtask

    task automatic test_backpressure_enable;
        logic [10:0] exp;
        ready = 1'b0; load = 1'b1; y = 8'b1000_0001;
        tick;
        load = 1'b0; y = 8'h00;
        for (int k = 0; k < 3; k++) begin
            exp = {3'd0, 4'b1100, 4'd2};
            checks++; if (st0 !== exp) begin errors++; $display("FAIL backpressure hold %0d: got %b expected %b", k, st0, exp); end
            tick;
        end
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick;
            exp = {3'd0, 4'b0100, 4'd2};
            checks++; if (st0 !== exp) begin errors++; $display("FAIL enable_low %0d: got %b expected %b", k, st0, exp); end
            exp = {3'd7, 4'b0100, 4'd2};
            checks++; if (st1 !== exp) begin errors++; $display("FAIL enable_low_msb %0d: got %b expected %b", k, st1, exp); end
        end
        enable = 1'b1; ready = 1'b1;
        #1;
        exp = {3'd0, 4'b1100, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL enable_resume: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd7, 4'b1100, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL resume_second: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd0, 4'b0010, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL resume_done: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd0, 4'b0000, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL resume_done_clear: got %b expected %b", st0, exp); end
        enable = 1'b0; load = 1'b1; y = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++; if (st0 !== exp) begin errors++; $display("FAIL idle_enable_low %0d: got %b expected %b", k, st0, exp); end
        end
        enable = 1'b1; load = 1'b0; y = 8'h00;
    endtask

    task automatic test_empty;
        logic [10:0] exp;
        load = 1'b1; y = 8'h00;
        tick;
        load = 1'b0;
        exp = {3'd0, 4'b0001, 4'd0};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL empty_vazio: got %b expected %b", st0, exp); end
        exp = '0;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++; if (st0 !== exp) begin errors++; $display("FAIL empty_after %0d: got %b expected %b", k, st0, exp); end
        end
    endtask

    task automatic test_load_busy;
        logic [10:0] exp;
        ready = 1'b1; load = 1'b1; y = 8'h0F;
        tick;
        y = 8'hF0;
        exp = {3'd0, 4'b1100, 4'd4};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL load_busy step 0: got %b expected %b", st0, exp); end
        tick;
        load = 1'b0; y = 8'h00;
        for (int k = 1; k < 4; k++) begin
            exp = {3'(k), 4'b1100, 4'd4};
            checks++; if (st0 !== exp) begin errors++; $display("FAIL load_busy step %0d: got %b expected %b", k, st0, exp); end
            tick;
        end
        exp = {3'd0, 4'b0010, 4'd4};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL load_busy_done: got %b expected %b", st0, exp); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [10:0] exp;
        ready = 1'b1; load = 1'b1; y = 8'h03;
        tick;
        load = 1'b0;
        exp = {3'd0, 4'b1100, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b first: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd1, 4'b1100, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b second: got %b expected %b", st0, exp); end
        load = 1'b1; y = 8'h0F;
        tick;
        exp = {3'd0, 4'b0010, 4'd2};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b load_on_final: got %b expected %b", st0, exp); end
        tick;
        load = 1'b0; y = 8'h00;
        for (int k = 0; k < 4; k++) begin
            exp = {3'(k), 4'b1100, 4'd4};
            checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b reload step %0d: got %b expected %b", k, st0, exp); end
            tick;
        end
        exp = {3'd0, 4'b0010, 4'd4};
        checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b reload_done: got %b expected %b", st0, exp); end
        tick;
    endtask

    task automatic test_msb_first;
        logic [10:0] exp;
        logic [2:0] e1 [3];
        e1 = '{3'd6, 3'd3, 3'd0};
        ready = 1'b1; load = 1'b1; y = 8'b0100_1001;
        tick;
        load = 1'b0; y = 8'h00;
        for (int k = 0; k < 3; k++) begin
            exp = {e1[k], 4'b1100, 4'd3};
            checks++; if (st1 !== exp) begin errors++; $display("FAIL msb_first step %0d: got %b expected %b", k, st1, exp); end
            tick;
        end
        exp = {3'd0, 4'b0010, 4'd3};
        checks++; if (st1 !== exp) begin errors++; $display("FAIL msb_first_done: got %b expected %b", st1, exp); end
        load = 1'b1; y = 8'h80;
        tick;
        load = 1'b0; y = 8'h00;
        exp = {3'd7, 4'b1100, 4'd1};
        checks++; if (st1 !== exp) begin errors++; $display("FAIL single_bit_msb: got %b expected %b", st1, exp); end
        checks++; if (st0 !== exp) begin errors++; $display("FAIL single_bit_lsb: got %b expected %b", st0, exp); end
        tick;
        exp = {3'd0, 4'b0010, 4'd1};
        checks++; if (st1 !== exp) begin errors++; $display("FAIL single_bit_done: got %b expected %b", st1, exp); end
        tick;
        exp = {3'd0, 4'b0000, 4'd1};
        checks++; if (st1 !== exp) begin errors++; $display("FAIL single_bit_after: got %b expected %b", st1, exp); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; load = 1'b0; y = 8'h00; ready = 1'b0;
        #12;
        test_reset;
        test_lsb_stream;
        test_backpressure_enable;
        test_empty;
        test_load_busy;
        test_back_to_back;
        test_msb_first;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codificador_sequencial.md
Name: codificador_sequencial

Overview:
- Encoder counterpart of the 3-to-8 one-hot decoder in the 8-bit ULA datapath.
- Captures an 8-bit request vector and emits the 3-bit index of every set bit, one index per accepted handshake, in priority order.
- Feeds operation-select codes back toward decoder-driven units; the `enable` semantics match the decoder's (enable low = block inert).

Parameters:
- LARGURA, 8, width of the request vector; must be a power of two, at least 2.
- SEL, 3, index width; must equal log2(LARGURA).
- MSB_PRIMEIRO, 0, priority order: 0 = lowest set bit emitted first, 1 = highest set bit emitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  global enable; when low, state is frozen, `valid` is forced 0, and `load`/`ready` are ignored.
- load  input  1  single-cycle request to capture `y`.
- y  input  LARGURA  request vector; any number of bits may be set.
- ready  input  1  consumer accepts the current index.
- a  output  SEL  index of the current highest-priority pending bit.
- valid  output  1  `a` is meaningful.
- busy  output  1  vector held, emission in progress.
- vazio  output  1  one-cycle pulse: `load` was accepted with y == 0.
- done  output  1  one-cycle pulse: last index accepted.
- qtd  output  SEL+1  popcount of the last captured vector.

Behaviour:
- Reset (async, `rst` = 1): state = IDLE; pending register = 0; a = 0; valid = 0; busy = 0; vazio = 0; done = 0; qtd = 0. The reset takes effect immediately, including mid-emission, and abandons any pending bits.
- States: IDLE, EMIT.
- IDLE:
  - Condition to accept: enable = 1 and load = 1 at a clock edge.
  - Accepting a load captures pend <= y and qtd <= popcount(y).
  - If y != 0, go to EMIT.
  - If y == 0, stay in IDLE and assert `vazio` for exactly the next cycle.
- EMIT:
  - a = priority index of `pend`: lowest set bit if MSB_PRIMEIRO = 0, highest set bit if MSB_PRIMEIRO = 1.
  - valid = enable; busy = 1.
- Timing of outputs:
  - `a`, `valid` and `busy` are derived only from registered state and `enable`; there is no combinational path from `y`, `load` or `ready` to outputs.
  - First `valid` appears in the cycle after `load` is accepted (latency 1).
- Handshake:
  - A transfer occurs at a clock edge with valid = 1 and ready = 1.
  - On a transfer, the bit pend[a] is cleared.
  - If that was the last set bit: return to IDLE, valid drops the next cycle, and `done` pulses for one cycle.
  - Otherwise `a` updates to the next index in the next cycle.
  - With ready held high, throughput is one index per cycle, with no bubbles.
- ready = 0: `a` and `valid` hold stable until accepted.
- `load` while in EMIT is ignored. `pend` and `qtd` are unchanged. There is no error flag.
- `load` and a final transfer in the same cycle: the `load` is ignored, because state was EMIT at that edge. A new `load` is accepted only from IDLE.
- enable = 0 in EMIT: valid = 0, `pend` is held, no transfer occurs. Emission resumes with the same `a` once enable returns to 1.
- enable = 0 in IDLE: `load` is ignored and `vazio` does not pulse.
- `qtd` holds its value until the next accepted `load`.
- `vazio` and `done` are never asserted simultaneously. Neither is asserted in the cycle after reset deassertion.
- Width rule: `qtd` ranges 0..LARGURA and therefore needs SEL+1 bits.

Test Plan:
- Reset value check: drive rst = 1 mid-EMIT with y = 8'hFF loaded -> a = 0, valid = 0, busy = 0, qtd = 0 immediately (asynchronously); after release, `load` works normally.
- LSB-first stream: MSB_PRIMEIRO = 0, load y = 8'b1010_0110, ready = 1 -> qtd = 4; a = 1, 2, 5, 7 on 4 consecutive cycles starting 1 cycle after `load`; `done` pulses with the cycle after a = 7 is accepted; busy = 0 afterwards.
- Backpressure and enable: y = 8'b1000_0001, ready = 0 for 3 cycles -> a = 0 and valid held; then enable = 0 for 2 cycles -> valid = 0 with a = 0 held; then enable = 1, ready = 1 -> a = 0 then a = 7; `done` pulses once.
- Empty vector: load y = 0 -> `vazio` = 1 for exactly one cycle, qtd = 0, valid never rises, state stays IDLE.
- Load while busy: load y = 8'h0F, then load y = 8'hF0 during EMIT -> emitted sequence is exactly 0, 1, 2, 3, and qtd stays 4.
- MSB-first variant: MSB_PRIMEIRO = 1, load y = 8'b0100_1001, ready = 1 -> a = 6, 3, 0; single bit y = 8'h80 -> a = 7, with `done` pulsing after one transfer.
